screen_sequencer: RTL and testbench
===================================

# screen_sequencer

Frame-aligned game-flow controller that sequences the start screen, game and end screen renderers and gates the game datapath. Sits between the push-button/switch inputs and the VGA colour mux: it owns the screen-select code, the game run-enable, a pre-game countdown, pause, and a minimum end-screen hold. All state changes take effect only at a frame boundary, so a screen never switches mid-frame.

## Interface
Parameters:
- COUNT_FRAMES, 60, frames per countdown step (1..255)
- COUNT_STEPS, 3, countdown steps before play starts (1..3)
- END_HOLD_FRAMES, 120, minimum frames on the end screen before reset_game is honoured (1..255)

Ports:
- CLK  in  1  100 MHz system clock; the block uses one clock
- RST  in  1  synchronous, active-low reset
- frame_tick  in  1  one-CLK pulse at the start of each frame (already in CLK domain)
- start_game  in  1  raw button, asynchronous
- reset_game  in  1  raw button, asynchronous
- pause_sw  in  1  raw switch, asynchronous; level 1 requests pause
- end_game  in  1  collision flag from game logic, CLK domain, level
- screen_sel  out  2  0 = start, 1 = game, 2 = end; 3 is never driven
- game_run  out  1  enables game motion, scoring and obstacle generation
- game_clear  out  1  one-CLK pulse that clears score and obstacle state
- count_val  out  2  countdown digit for overlay; 0 when not counting
- paused  out  1  high in PAUSE

## Operation
- Input conditioning: start_game, reset_game and pause_sw each pass through a 2-FF synchroniser. The buttons are rising-edge detected on the synchronised value. Each edge sets a sticky pending flag. pause_sw is used as a synchronised level.
- Pending flags clear only on the frame_tick that consumes or discards them. end_game is sampled as a level on frame_tick.
- States: IDLE, COUNT, PLAY, PAUSE, OVER. Every transition is evaluated only in the CLK cycle where frame_tick = 1.
- Transitions on frame_tick, in priority order:
  - IDLE: start pending → COUNT; game_clear pulses; load step = COUNT_STEPS, frame counter = 0.
  - COUNT: reset pending → IDLE. Otherwise the frame counter increments; when it reaches COUNT_FRAMES-1 it resets to 0 and step decrements. When step would go to 0, go to PLAY.
  - PLAY: reset pending → IDLE. Else end_game = 1 → OVER; hold counter = 0. Else pause_sw = 1 → PAUSE.
  - PAUSE: reset pending → IDLE. Else pause_sw = 0 → PLAY. end_game is ignored in PAUSE.
  - OVER: hold counter saturates at END_HOLD_FRAMES. A reset pending with hold counter ≥ END_HOLD_FRAMES → IDLE. A reset pending earlier is discarded. A start pending with hold ≥ END_HOLD_FRAMES → COUNT with game_clear.
- All pending flags are cleared on every frame_tick, whether used or discarded.
- Output decode, registered, updated in the same cycle as the state:
  - IDLE: screen_sel = 0.
  - COUNT, PLAY, PAUSE: screen_sel = 1.
  - OVER: screen_sel = 2.
  - game_run = 1 only in PLAY.
  - count_val = step in COUNT, else 0.
  - paused = 1 only in PAUSE.
- Width rules: frame and hold counters are 8 bits unsigned; step is 2 bits. Counters never wrap; the hold counter saturates.

## Timing
- Reset (RST = 0 at a CLK edge): state = IDLE, screen_sel = 0, game_run = 0, game_clear = 0, count_val = 0, paused = 0. Synchronisers, edge detectors, pending flags and counters are all zeroed.
- A reset asserted mid-countdown or mid-play takes effect at the next edge, independent of frame_tick.
- Button latency: a raw edge sets pending 3 CLK cycles later (2 synchroniser stages + edge register). The state change occurs at the first frame_tick after pending is set.
- An edge arriving in the same cycle as frame_tick, or within the 3-cycle pipeline, is serviced on the following frame.
- Outputs change exactly 1 CLK after the frame_tick edge that causes the transition.
- game_clear is high for exactly 1 CLK, concurrent with the first cycle of COUNT.
- Countdown duration: PLAY is entered exactly COUNT_STEPS × COUNT_FRAMES frame_ticks after entering COUNT.
- Simultaneous start and reset pending: reset wins in every state; start is discarded.
- Simultaneous end_game = 1 and pause_sw = 1 in PLAY: end_game wins (OVER).
- A held button produces one event only; a new rising edge is needed for another.

## Test plan
- Reset release, no inputs, 10 frames → screen_sel = 0, game_run = 0, game_clear never pulses.
- start_game pulse, defaults → game_clear pulses once. count_val reads 3, 2, 1, each for 60 frames. screen_sel = 1 throughout. game_run = 1 exactly 180 frame_ticks after COUNT is entered.
- In PLAY, raise end_game → screen_sel = 2 one CLK after the next frame_tick; game_run = 0.
  - reset_game pressed 50 frames later → ignored, state stays OVER.
  - reset_game pressed at frame 130 → IDLE.
- In PLAY, pause_sw = 1 → paused = 1, game_run = 0. end_game = 1 while paused → state stays PAUSE. pause_sw = 0 → PLAY.
- start_game and reset_game edges in the same cycle during COUNT → IDLE, no game_clear.
  - Button edge 1 cycle before frame_tick → transition deferred to the following frame.
- RST = 0 asserted mid-PLAY → all outputs return to reset values on the next CLK edge.

Source files
------------

// File: rtl/screen_sequencer.sv
// screen_sequencer: frame-aligned game-flow FSM.
// Owns screen select, run-enable, countdown, pause and end hold.
module screen_sequencer #(
  parameter int COUNT_FRAMES    = 60,
  parameter int COUNT_STEPS     = 3,
  parameter int END_HOLD_FRAMES = 120
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       frame_tick,
  input  logic       start_game,
  input  logic       reset_game,
  input  logic       pause_sw,
  input  logic       end_game,
  output logic [1:0] screen_sel,
  output logic       game_run,
  output logic       game_clear,
  output logic [1:0] count_val,
  output logic       paused
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_COUNT,
    S_PLAY,
    S_PAUSE,
    S_OVER
  } state_t;

  localparam logic [7:0] FRAMES_M1 = 8'(COUNT_FRAMES - 1);
  localparam logic [7:0] HOLD_MAX  = 8'(END_HOLD_FRAMES);
  localparam logic [1:0] STEPS     = 2'(COUNT_STEPS);

  logic [1:0] r_start_sync;
  logic [1:0] r_reset_sync;
  logic [1:0] r_pause_sync;
  logic       r_start_d;
  logic       r_reset_d;
  logic       r_start_pend;
  logic       r_reset_pend;

  state_t     r_state;
  logic [7:0] r_frame_cnt;
  logic [7:0] r_hold_cnt;
  logic [1:0] r_step;
  logic [1:0] r_screen_sel;
  logic       r_game_run;
  logic       r_game_clear;
  logic [1:0] r_count_val;
  logic       r_paused;

  logic       w_start_edge;
  logic       w_reset_edge;
  logic       w_start_pend_nxt;
  logic       w_reset_pend_nxt;
  logic       w_pause;
  logic       w_hold_met;

  state_t     w_state_nxt;
  logic [7:0] w_frame_nxt;
  logic [7:0] w_hold_nxt;
  logic [1:0] w_step_nxt;
  logic       w_clear_nxt;
  logic [1:0] w_sel_nxt;

  assign w_start_edge = r_start_sync[1] & ~r_start_d;
  assign w_reset_edge = r_reset_sync[1] & ~r_reset_d;
  assign w_pause      = r_pause_sync[1];
  assign w_hold_met   = (r_hold_cnt >= HOLD_MAX);

  // An edge seen on the tick cycle survives into the next frame.
  assign w_start_pend_nxt = frame_tick ? w_start_edge
                                       : (r_start_pend | w_start_edge);
  assign w_reset_pend_nxt = frame_tick ? w_reset_edge
                                       : (r_reset_pend | w_reset_edge);

  // Synchronisers, edge registers and sticky pending flags.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      r_start_sync <= '0;
      r_reset_sync <= '0;
      r_pause_sync <= '0;
      r_start_d    <= 1'b0;
      r_reset_d    <= 1'b0;
      r_start_pend <= 1'b0;
      r_reset_pend <= 1'b0;
    end else begin
      r_start_sync <= {r_start_sync[0], start_game};
      r_reset_sync <= {r_reset_sync[0], reset_game};
      r_pause_sync <= {r_pause_sync[0], pause_sw};
      r_start_d    <= r_start_sync[1];
      r_reset_d    <= r_reset_sync[1];
      r_start_pend <= w_start_pend_nxt;
      r_reset_pend <= w_reset_pend_nxt;
    end
  end

  // Next state, counters and output decode; moves only on frame_tick.
  always_comb begin
    w_state_nxt = r_state;
    w_frame_nxt = r_frame_cnt;
    w_hold_nxt  = r_hold_cnt;
    w_step_nxt  = r_step;
    w_clear_nxt = 1'b0;
    if (frame_tick) begin
      unique case (r_state)
        S_IDLE: begin
          if (!r_reset_pend && r_start_pend) begin
            w_state_nxt = S_COUNT;
            w_clear_nxt = 1'b1;
            w_step_nxt  = STEPS;
            w_frame_nxt = '0;
          end
        end
        S_COUNT: begin
          if (r_reset_pend) begin
            w_state_nxt = S_IDLE;
          end else if (r_frame_cnt == FRAMES_M1) begin
            w_frame_nxt = '0;
            if (r_step == 2'd1) begin
              w_step_nxt  = '0;
              w_state_nxt = S_PLAY;
            end else begin
              w_step_nxt = r_step - 2'd1;
            end
          end else begin
            w_frame_nxt = r_frame_cnt + 8'd1;
          end
        end
        S_PLAY: begin
          if (r_reset_pend) begin
            w_state_nxt = S_IDLE;
          end else if (end_game) begin
            w_state_nxt = S_OVER;
            w_hold_nxt  = '0;
          end else if (w_pause) begin
            w_state_nxt = S_PAUSE;
          end
        end
        S_PAUSE: begin
          if (r_reset_pend) begin
            w_state_nxt = S_IDLE;
          end else if (!w_pause) begin
            w_state_nxt = S_PLAY;
          end
        end
        S_OVER: begin
          if (w_hold_met && r_reset_pend) begin
            w_state_nxt = S_IDLE;
          end else if (w_hold_met && r_start_pend) begin
            w_state_nxt = S_COUNT;
            w_clear_nxt = 1'b1;
            w_step_nxt  = STEPS;
            w_frame_nxt = '0;
          end else if (!w_hold_met) begin
            w_hold_nxt = r_hold_cnt + 8'd1;
          end
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
    unique case (w_state_nxt)
      S_IDLE:  w_sel_nxt = 2'd0;
      S_OVER:  w_sel_nxt = 2'd2;
      default: w_sel_nxt = 2'd1;
    endcase
  end

  // State, counters and registered outputs.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      r_state      <= S_IDLE;
      r_frame_cnt  <= '0;
      r_hold_cnt   <= '0;
      r_step       <= '0;
      r_screen_sel <= '0;
      r_game_run   <= 1'b0;
      r_game_clear <= 1'b0;
      r_count_val  <= '0;
      r_paused     <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_frame_cnt  <= w_frame_nxt;
      r_hold_cnt   <= w_hold_nxt;
      r_step       <= w_step_nxt;
      r_screen_sel <= w_sel_nxt;
      r_game_run   <= (w_state_nxt == S_PLAY);
      r_game_clear <= w_clear_nxt;
      r_count_val  <= (w_state_nxt == S_COUNT) ? w_step_nxt : 2'd0;
      r_paused     <= (w_state_nxt == S_PAUSE);
    end
  end

  assign screen_sel = r_screen_sel;
  assign game_run   = r_game_run;
  assign game_clear = r_game_clear;
  assign count_val  = r_count_val;
  assign paused     = r_paused;

endmodule

// File: tb/tb_screen_sequencer.sv
// tb_screen_sequencer: frame-level vector table plus
// cycle-level sequences for button timing and reset.
module tb_screen_sequencer;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic       frame_tick = 1'b0;
  logic       start_game = 1'b0;
  logic       reset_game = 1'b0;
  logic       pause_sw = 1'b0;
  logic       end_game = 1'b0;
  logic [1:0] screen_sel;
  logic       game_run;
  logic       game_clear;
  logic [1:0] count_val;
  logic       paused;

  int checks = 0;
  int errors = 0;
  int clr_cnt = 0;

  always #5 CLK = ~CLK;

  screen_sequencer dut (
    .CLK        (CLK),
    .RST        (RST),
    .frame_tick (frame_tick),
    .start_game (start_game),
    .reset_game (reset_game),
    .pause_sw   (pause_sw),
    .end_game   (end_game),
    .screen_sel (screen_sel),
    .game_run   (game_run),
    .game_clear (game_clear),
    .count_val  (count_val),
    .paused     (paused)
  );

  always @(negedge CLK)
    if (game_clear === 1'b1) clr_cnt++;

  typedef struct {
    int         nfr;
    int         sw;
    int         rw;
    bit         p;
    bit         e;
    logic [1:0] sel;
    logic       run;
    logic [1:0] cv;
    logic       pz;
    logic       clr;
    int         clrs;
  } vec_t;

  vec_t vecs [20];

  task automatic chk(input string nm, input int idx,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d]: got %0d expected %0d",
               nm, idx, act, exp);
    end
  endtask

  task automatic chk_all(input int idx, input logic [1:0] sel,
                         input logic run, input logic [1:0] cv,
                         input logic pz, input logic clr,
                         input int clrs);
    chk("screen_sel", idx, 32'(screen_sel), 32'(sel));
    chk("game_run", idx, 32'(game_run), 32'(run));
    chk("count_val", idx, 32'(count_val), 32'(cv));
    chk("paused", idx, 32'(paused), 32'(pz));
    chk("game_clear", idx, 32'(game_clear), 32'(clr));
    chk("clear_count", idx, 32'(clr_cnt), 32'(clrs));
  endtask

  // One 8-cycle frame, tick on the last cycle; buttons high for
  // sw/rw cycles from cycle bs. Ends #1 after the first negedge
  // following the tick edge.
  task automatic run_frame(input int sw, input int rw,
                           input bit p, input bit e,
                           input int bs);
    for (int c = 0; c < 8; c++) begin
      @(negedge CLK);
      frame_tick = (c == 7);
      start_game = (c >= bs) && (c < bs + sw);
      reset_game = (c >= bs) && (c < bs + rw);
      pause_sw   = p;
      end_game   = e;
    end
    @(negedge CLK);
    frame_tick = 1'b0;
    #1;
  endtask

  task automatic set_vec(input int i, input int nfr,
                         input int sw, input int rw,
                         input bit p, input bit e,
                         input logic [1:0] sel, input logic run,
                         input logic [1:0] cv, input logic pz,
                         input logic clr, input int clrs);
    vecs[i].nfr = nfr;
    vecs[i].sw = sw;
    vecs[i].rw = rw;
    vecs[i].p = p;
    vecs[i].e = e;
    vecs[i].sel = sel;
    vecs[i].run = run;
    vecs[i].cv = cv;
    vecs[i].pz = pz;
    vecs[i].clr = clr;
    vecs[i].clrs = clrs;
  endtask

  initial begin
    // nfr sw rw p e | sel run cv pz clr clrs
    set_vec(0, 10, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    set_vec(1, 1, 3, 0, 0, 0, 1, 0, 3, 0, 1, 1);
    set_vec(2, 59, 0, 0, 0, 0, 1, 0, 3, 0, 0, 1);
    set_vec(3, 1, 0, 0, 0, 0, 1, 0, 2, 0, 0, 1);
    set_vec(4, 59, 0, 0, 0, 0, 1, 0, 2, 0, 0, 1);
    set_vec(5, 1, 0, 0, 0, 0, 1, 0, 1, 0, 0, 1);
    set_vec(6, 59, 0, 0, 0, 0, 1, 0, 1, 0, 0, 1);
    set_vec(7, 1, 0, 0, 0, 0, 1, 1, 0, 0, 0, 1);
    set_vec(8, 1, 0, 0, 1, 0, 1, 0, 0, 1, 0, 1);
    set_vec(9, 1, 0, 0, 1, 1, 1, 0, 0, 1, 0, 1);
    set_vec(10, 1, 0, 0, 0, 0, 1, 1, 0, 0, 0, 1);
    set_vec(11, 1, 0, 0, 1, 1, 2, 0, 0, 0, 0, 1);
    set_vec(12, 50, 0, 3, 0, 0, 2, 0, 0, 0, 0, 1);
    set_vec(13, 69, 0, 0, 0, 0, 2, 0, 0, 0, 0, 1);
    set_vec(14, 1, 0, 3, 0, 0, 2, 0, 0, 0, 0, 1);
    set_vec(15, 9, 0, 0, 0, 0, 2, 0, 0, 0, 0, 1);
    set_vec(16, 1, 0, 3, 0, 0, 0, 0, 0, 0, 0, 1);
    set_vec(17, 1, 3, 0, 0, 0, 1, 0, 3, 0, 1, 2);
    set_vec(18, 1, 3, 3, 0, 0, 0, 0, 0, 0, 0, 2);
    set_vec(19, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2);

    repeat (3) @(negedge CLK);
    #1;
    chk_all(100, 0, 0, 0, 0, 0, 0);
    RST = 1'b1;

    for (int i = 0; i < 20; i++) begin
      for (int k = 0; k < vecs[i].nfr; k++)
        run_frame((k == 0) ? vecs[i].sw : 0,
                  (k == 0) ? vecs[i].rw : 0,
                  vecs[i].p, vecs[i].e, 0);
      chk_all(i, vecs[i].sel, vecs[i].run, vecs[i].cv,
              vecs[i].pz, vecs[i].clr, vecs[i].clrs);
    end

    // Edge lands on the tick cycle: serviced one frame later.
    run_frame(3, 0, 0, 0, 5);
    chk_all(200, 0, 0, 0, 0, 0, 2);
    run_frame(0, 0, 0, 0, 0);
    chk_all(201, 1, 0, 3, 0, 1, 3);

    // Pending set one cycle before the tick: taken this frame.
    run_frame(0, 3, 0, 0, 4);
    chk_all(202, 0, 0, 0, 0, 0, 3);

    run_frame(3, 0, 0, 0, 0);
    chk_all(203, 1, 0, 3, 0, 1, 4);
    for (int k = 0; k < 180; k++)
      run_frame(0, 0, 0, 0, 0);
    chk_all(204, 1, 1, 0, 0, 0, 4);

    // Synchronous reset mid-play, no frame_tick needed.
    @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);
    #1;
    chk_all(205, 0, 0, 0, 0, 0, 4);
    RST = 1'b1;

    // Held reset yields one event; a later start still works.
    for (int k = 0; k < 3; k++)
      run_frame(0, 8, 0, 0, 0);
    chk_all(206, 0, 0, 0, 0, 0, 4);
    run_frame(3, 8, 0, 0, 0);
    chk_all(207, 1, 0, 3, 0, 1, 5);
    run_frame(0, 0, 0, 0, 0);
    chk_all(208, 1, 0, 3, 0, 0, 5);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
